// File: rtl/scg_timed.sv
// SDRAM command-sequence generator: one start pulse issues ACTIVE, PRECHARGE,
// PRECHARGE ALL or AUTO REFRESH, then holds NOP for the op's timing interval.
module scg_timed #(
    parameter int ROW_W  = 13,
    parameter int BANK_W = 2,
    parameter int TRCD   = 2,
    parameter int TRP    = 2,
    parameter int TRFC   = 7,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [BANK_W-1:0] bank_in,
    input  logic [ROW_W-1:0]  row_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        command,
    output logic [BANK_W-1:0] ba,
    output logic [ROW_W-1:0]  addr
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ACT = 2'b00, OP_PRE = 2'b01, OP_PALL = 2'b10, OP_REF = 2'b11} op_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam logic [CNT_W-1:0] TRCD_M1 = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] TRP_M1  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] TRFC_M1 = CNT_W'(TRFC - 1);

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                capture;
    logic [CNT_W-1:0]    t_m1;

    // Requests are only accepted when no sequence is in flight.
    assign capture = start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        case (op_q)
            OP_ACT:  t_m1 = TRCD_M1;
            OP_REF:  t_m1 = TRFC_M1;
            default: t_m1 = TRP_M1;
        endcase
    end

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        bank_d  = bank_q;
        row_d   = row_q;
        if (capture) begin
            op_d   = op_t'(op);
            bank_d = bank_in;
            row_d  = row_in;
        end
        case (state_q)
            S_IDLE:  if (capture) state_d = S_ISSUE;
            S_ISSUE: begin
                cnt_d   = t_m1;
                state_d = (t_m1 != '0) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE:  state_d = capture ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ACT;
            bank_q  <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
        end
    end

    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done = (state_q == S_DONE);

    // Pins carry the command only during ISSUE; every other state drives NOP with zeroed buses.
    always_comb begin
        command = CMD_NOP;
        ba      = '0;
        addr    = '0;
        if (state_q == S_ISSUE) begin
            case (op_q)
                OP_ACT: begin
                    command = CMD_ACT;
                    ba      = bank_q;
                    addr    = row_q;
                end
                OP_PRE: begin
                    command = CMD_PRE;
                    ba      = bank_q;
                end
                OP_PALL: begin
                    command = CMD_PRE;
                    addr    = ROW_W'(1) << 10;
                end
                default: command = CMD_REF;
            endcase
        end
    end

endmodule

// File: tb/tb_scg_timed.sv
// Directed bench for scg_timed: default timing plus a TRFC=1 instance for the
// no-WAIT refresh path.
module tb_scg_timed;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start, start2;
    logic [1:0]  op;
    logic [1:0]  bank_in;
    logic [12:0] row_in;

    logic        busy, done, busy2, done2;
    logic [3:0]  command, command2;
    logic [1:0]  ba, ba2;
    logic [12:0] addr, addr2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scg_timed dut (
        .clk(clk), .n_rst(n_rst), .start(start), .op(op), .bank_in(bank_in),
        .row_in(row_in), .busy(busy), .done(done), .command(command), .ba(ba), .addr(addr)
    );

    scg_timed #(.TRFC(1)) dut_trfc1 (
        .clk(clk), .n_rst(n_rst), .start(start2), .op(op), .bank_in(bank_in),
        .row_in(row_in), .busy(busy2), .done(done2), .command(command2), .ba(ba2), .addr(addr2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".cmd"}, 32'(command), 32'h7);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".done"}, 32'(done), 32'h0);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; start2 = 1'b0;
        op = 2'b00; bank_in = '0; row_in = '0;
        tick(); tick();
        check_idle("rst");
        check("rst.ba", 32'(ba), 32'h0);
        check("rst.addr", 32'(addr), 32'h0);
        n_rst = 1'b1;
        tick();

        // ACTIVE, TRCD=2
        op = 2'b00; bank_in = 2'd2; row_in = 13'h1A5; start = 1'b1;
        tick(); start = 1'b0;
        check("act.issue.cmd", 32'(command), 32'h3);
        check("act.issue.ba", 32'(ba), 32'h2);
        check("act.issue.addr", 32'(addr), 32'h1A5);
        check("act.issue.busy", 32'(busy), 32'h1);
        tick();
        check("act.wait.cmd", 32'(command), 32'h7);
        check("act.wait.busy", 32'(busy), 32'h1);
        check("act.wait.addr", 32'(addr), 32'h0);
        check("act.wait.done", 32'(done), 32'h0);
        tick();
        check("act.done.done", 32'(done), 32'h1);
        check("act.done.busy", 32'(busy), 32'h0);
        tick();
        check_idle("act.idle");

        // PRECHARGE ALL ignores bank_in
        op = 2'b10; bank_in = 2'd3; row_in = 13'h0123; start = 1'b1;
        tick(); start = 1'b0;
        check("pall.cmd", 32'(command), 32'h2);
        check("pall.ba", 32'(ba), 32'h0);
        check("pall.addr", 32'(addr), 32'h400);
        tick();
        check("pall.wait.done", 32'(done), 32'h0);
        check("pall.wait.busy", 32'(busy), 32'h1);
        tick();
        check("pall.done", 32'(done), 32'h1);
        tick();

        // PRECHARGE single bank: A10 low, row ignored
        op = 2'b01; bank_in = 2'd1; row_in = 13'h1FFF; start = 1'b1;
        tick(); start = 1'b0;
        check("pre.cmd", 32'(command), 32'h2);
        check("pre.ba", 32'(ba), 32'h1);
        check("pre.addr", 32'(addr), 32'h0);
        tick(); tick();
        check("pre.done", 32'(done), 32'h1);
        tick();

        // AUTO REFRESH, TRFC=7: one REF cycle, six NOP/busy cycles, then done
        op = 2'b11; bank_in = 2'd2; row_in = 13'h0AAA; start = 1'b1;
        tick(); start = 1'b0;
        check("ref.cmd", 32'(command), 32'h1);
        check("ref.ba", 32'(ba), 32'h0);
        check("ref.addr", 32'(addr), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ref.wait%0d.cmd", i), 32'(command), 32'h7);
            check($sformatf("ref.wait%0d.busy", i), 32'(busy), 32'h1);
            check($sformatf("ref.wait%0d.done", i), 32'(done), 32'h0);
        end
        tick();
        check("ref.done", 32'(done), 32'h1);
        tick();
        check_idle("ref.idle");

        // AUTO REFRESH with TRFC=1: done directly after ISSUE
        op = 2'b11; start2 = 1'b1;
        tick(); start2 = 1'b0;
        check("ref1.cmd", 32'(command2), 32'h1);
        check("ref1.busy", 32'(busy2), 32'h1);
        tick();
        check("ref1.done", 32'(done2), 32'h1);
        check("ref1.done.cmd", 32'(command2), 32'h7);
        check("ref1.done.busy", 32'(busy2), 32'h0);
        tick();
        check("ref1.idle.done", 32'(done2), 32'h0);
        check("ref1.main_idle", 32'(busy), 32'h0);

        // start held through ISSUE/WAIT with new op/bank is ignored
        op = 2'b00; bank_in = 2'd1; row_in = 13'h0055; start = 1'b1;
        tick();
        op = 2'b11; bank_in = 2'd3;
        check("busy.issue.cmd", 32'(command), 32'h3);
        check("busy.issue.ba", 32'(ba), 32'h1);
        check("busy.issue.addr", 32'(addr), 32'h55);
        tick();
        check("busy.wait.cmd", 32'(command), 32'h7);
        check("busy.wait.busy", 32'(busy), 32'h1);
        tick(); start = 1'b0;
        check("busy.done", 32'(done), 32'h1);
        check("busy.done.cmd", 32'(command), 32'h7);
        tick();
        check_idle("busy.idle");

        // Back-to-back: start in DONE goes straight to ISSUE
        op = 2'b00; bank_in = 2'd0; row_in = 13'h0010; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check("b2b.done1", 32'(done), 32'h1);
        op = 2'b01; bank_in = 2'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("b2b.issue.cmd", 32'(command), 32'h2);
        check("b2b.issue.ba", 32'(ba), 32'h2);
        check("b2b.issue.busy", 32'(busy), 32'h1);
        check("b2b.issue.done", 32'(done), 32'h0);
        tick(); tick();
        check("b2b.done2", 32'(done), 32'h1);
        tick();

        // Reset mid-WAIT of a refresh abandons the sequence
        op = 2'b11; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check("rstw.pre.busy", 32'(busy), 32'h1);
        n_rst = 1'b0;
        tick();
        check_idle("rstw");
        check("rstw.addr", 32'(addr), 32'h0);
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rstw.quiet%0d.done", i), 32'(done), 32'h0);
        end

        // Fresh ACTIVE after reset release
        op = 2'b00; bank_in = 2'd2; row_in = 13'h1A5; start = 1'b1;
        tick(); start = 1'b0;
        check("post.cmd", 32'(command), 32'h3);
        check("post.addr", 32'(addr), 32'h1A5);
        tick();
        check("post.wait.done", 32'(done), 32'h0);
        tick();
        check("post.done", 32'(done), 32'h1);
        tick();
        check_idle("post.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scg_timed.md
Name: scg_timed

Overview:
- Parametrised SDRAM command-sequence generator; the next generation of the single-command "active" sequencer.
- One start pulse issues exactly one bank/row-level SDRAM command: ACTIVE, PRECHARGE (single bank), PRECHARGE ALL or AUTO REFRESH.
- It drives the matching bank/address bits, then holds NOP for a per-command programmable timing interval (tRCD/tRP/tRFC) before signalling done.
- Sits between the controller's top-level FSM and the SDRAM pin mux.

Parameters:
- ROW_W, 13, row/address bus width; must be >= 11 (A10 is used as the auto-precharge/all-banks bit).
- BANK_W, 2, bank address width.
- TRCD, 2, cycles from ACTIVE issue to done; must be >= 1.
- TRP, 2, cycles from PRECHARGE / PRECHARGE ALL issue to done; must be >= 1.
- TRFC, 7, cycles from AUTO REFRESH issue to done; must be >= 1.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > max(TRCD, TRP, TRFC).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  2  00 ACTIVE, 01 PRECHARGE, 10 PRECHARGE ALL, 11 AUTO REFRESH; sampled with start.
- bank_in  input  BANK_W  target bank; sampled with start.
- row_in  input  ROW_W  target row; sampled with start, used by ACTIVE only.
- busy  output  1  high in ISSUE and WAIT.
- done  output  1  one-cycle pulse in DONE.
- command  output  4  {CS_n, RAS_n, CAS_n, WE_n}.
- ba  output  BANK_W  bank address.
- addr  output  ROW_W  SDRAM address bus.

Behaviour:
- Encodings: NOP 0111, ACTIVE 0011, PRECHARGE/PRECHARGE ALL 0010, AUTO REFRESH 0001.
- Reset: when n_rst=0 at a rising edge, state <= IDLE, counter <= 0, captured op/bank/row <= 0.
  - Resulting outputs: command=0111, ba=0, addr=0, busy=0, done=0.
  - Reset applies from any state, including mid-WAIT; the in-flight sequence is abandoned and done never pulses.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: outputs NOP, ba=0, addr=0. If start=1, capture op/bank_in/row_in; next state ISSUE.
- ISSUE (exactly 1 cycle): command = encoding for the captured op.
  - ACTIVE: ba=bank, addr=row.
  - PRECHARGE: ba=bank, addr=0 (A10=0).
  - PRECHARGE ALL: ba=0, addr has only bit 10 set.
  - AUTO REFRESH: ba=0, addr=0.
  - Load counter with T-1, where T is TRCD, TRP or TRFC for the op.
  - Next state is WAIT if T > 1, else DONE.
- WAIT: command=NOP, ba=0, addr=0. Counter decrements each cycle; when counter==1, next state DONE.
- Timing: if ISSUE is cycle k, DONE is exactly cycle k+T, and WAIT occupies cycles k+1 .. k+T-1.
- DONE (1 cycle): done=1, busy=0, command=NOP.
  - start=1 in DONE: capture new inputs and go directly to ISSUE (back-to-back, no IDLE cycle).
  - Otherwise go to IDLE.
- start in ISSUE or WAIT is ignored and not queued; op/bank_in/row_in changes while busy have no effect.
- Latency: start at cycle c (in IDLE) gives ISSUE at c+1 and done at c+1+T.
- command, ba and addr are combinational decodes of the state and the captured registers.
- Counter arithmetic is unsigned CNT_W bits; it never wraps in legal configurations.

Test Plan:
- Reset, then ACTIVE (TRCD=2): start=1 with op=00, bank_in=2, row_in=0x1A5 at cycle 0 -> cycle 1: command=0011, ba=2, addr=0x1A5, busy=1; cycle 2: command=0111, busy=1; cycle 3: done=1, busy=0; cycle 4: IDLE, done=0.
- PRECHARGE ALL (TRP=2) with bank_in=3 -> ISSUE: command=0010, ba=0, addr=0x400; done exactly 2 cycles after ISSUE. PRECHARGE with bank_in=1 -> ba=1, addr=0x000.
- AUTO REFRESH (TRFC=7) -> command=0001 for exactly one cycle, 6 NOP cycles with busy=1, done on the 7th cycle after ISSUE. Repeat with parameter override TRFC=1 -> done in the cycle immediately after ISSUE, no WAIT.
- Start while busy: second start with op=11 during WAIT of an ACTIVE -> ignored; only one ACTIVE issued, done at its original cycle, no extra command.
- Back-to-back: start=1 with op=01 in the DONE cycle of an ACTIVE -> the next cycle is ISSUE with command=0010 and no intervening IDLE cycle.
- Reset mid-WAIT: n_rst=0 during a REFRESH WAIT -> next edge gives command=0111, busy=0, done=0, addr=0; done never pulses; a new start after release behaves as in the first scenario.
